// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch request FSM encoding and fetch queue sizing.
// Build option: define FETCH_PREFETCH_EN for the 2-entry prefetching queue;
// otherwise a single entry is fetched only on demand.
package cpu_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWaitAck = 2'd1,
    StDiscard = 2'd2
  } fetch_state_e;

`ifdef FETCH_PREFETCH_EN
  localparam int unsigned FetchQDepth   = 2;
  localparam bit          FetchPrefetch = 1'b1;
`else
  localparam int unsigned FetchQDepth   = 1;
  localparam bit          FetchPrefetch = 1'b0;
`endif

endpackage

// File: rtl/fetch_queue.sv
// Small instruction queue: shift-down storage, head at entry 0.
// Depth comes from cpu_pkg (set by FETCH_PREFETCH_EN). Flush wins over push/pop.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH  = FetchQDepth,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic              pop,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head_data,
  output logic [ADDR_W-1:0] head_pc
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [ADDR_W-1:0] pc_d   [DEPTH];
  logic [CntW-1:0]   count_q, count_d;
  logic [CntW-1:0]   wr_idx;
  logic              pop_en, push_en;

  assign full      = (count_q == CntW'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_data = data_q[0];
  assign head_pc   = pc_q[0];

  assign pop_en  = pop && !empty;
  // A push into a full queue is only taken when the same-cycle pop frees a slot.
  assign push_en = push && (!full || pop_en);
  assign wr_idx  = pop_en ? count_q - 1'b1 : count_q;

  // Next-state storage: shift on pop, write new entry behind the survivors.
  always_comb begin
    data_d  = data_q;
    pc_d    = pc_q;
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      if (pop_en) begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
          data_d[i] = data_q[i+1];
          pc_d[i]   = pc_q[i+1];
        end
      end
      if (push_en) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (i == int'(wr_idx)) begin
            data_d[i] = push_data;
            pc_d[i]   = push_pc;
          end
        end
      end
      unique case ({push_en, pop_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      count_q <= count_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory read at a time, results
// queued for the control sequencer. Jumps flush the queue and discard any
// in-flight read. Build option FETCH_PREFETCH_EN (see cpu_pkg) enables
// prefetching into a 2-entry queue.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              halt
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] fetch_addr_q;
  logic              q_full, q_empty;
  logic              ack_ok, push, pop, can_issue, issue;

  assign ack_ok      = mem_req && mem_ack;
  assign instr_valid = !q_empty;
  // Jump takes priority: no push or pop in a redirect cycle.
  assign push        = (state_q == StWaitAck) && ack_ok && !jump;
  assign pop         = instr_valid && instr_ready && !jump;
  assign can_issue   = FetchPrefetch ? !q_full : (q_empty && instr_ready);
  // Never issue in a jump cycle, fetch_addr is about to change.
  assign issue       = (state_q == StIdle) && !halt && !jump && can_issue;

  // Request FSM with registered mem_req/mem_addr held from issue until ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      fetch_addr_q <= '0;
    end else begin
      if (jump) begin
        fetch_addr_q <= jump_addr;
      end
      unique case (state_q)
        StIdle: begin
          if (issue) begin
            state_q  <= StWaitAck;
            mem_req  <= 1'b1;
            mem_addr <= fetch_addr_q;
          end
        end
        StWaitAck: begin
          if (ack_ok) begin
            // Read completes; with a simultaneous jump its data is simply dropped.
            state_q <= StIdle;
            mem_req <= 1'b0;
            if (!jump) begin
              fetch_addr_q <= fetch_addr_q + 1'b1;
            end
          end else if (jump) begin
            state_q <= StDiscard;
          end
        end
        StDiscard: begin
          if (ack_ok) begin
            state_q <= StIdle;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  fetch_queue #(
    .DEPTH  (FetchQDepth),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (mem_rdata),
    .push_pc   (mem_addr + 1'b1),
    .pop       (pop),
    .flush     (jump),
    .full      (q_full),
    .empty     (q_empty),
    .head_data (instr),
    .head_pc   (instr_pc)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: memory responder, expected-instruction scoreboard
// and a monitor that checks every instruction the consumer accepts.
module tb_fetch_unit;

  typedef struct {
    logic [7:0] data;
    logic [7:0] pc;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       jump;
  logic [7:0] jump_addr;
  logic       halt;

  int         total = 0;
  int         bad = 0;
  int         ack_delay = 1;
  int         stray_req = 0;
  exp_t       exp_q[$];
  logic [7:0] req_log[$];

  fetch_unit #(
    .ADDR_W (8),
    .DATA_W (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .jump        (jump),
    .jump_addr   (jump_addr),
    .halt        (halt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] mem_fn(input logic [7:0] a);
    return a ^ 8'h5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic [7:0] p);
    exp_t e;
    e.data = d;
    e.pc   = p;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!mem_req && n < 100) begin
      step();
      n++;
    end
    if (!mem_req) timeout(name);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      timeout(name);
      exp_q.delete();
    end
  endtask

  // Stop fetching, let any read finish, then flush and repoint via a jump.
  task automatic quiesce(input logic [7:0] addr);
    int n = 0;
    halt        = 1'b1;
    instr_ready = 1'b0;
    ack_delay   = 1;
    while (mem_req && n < 100) begin
      step();
      n++;
    end
    if (mem_req) timeout("quiesce");
    step();
    jump      = 1'b1;
    jump_addr = addr;
    step();
    jump = 1'b0;
    req_log.delete();
  endtask

  // Memory model: acks ack_delay cycles after a request, logs each request address.
  initial begin
    int wait_cnt = 0;
    int stray_done = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (stray_req != stray_done) begin
        stray_done = stray_req;
        mem_ack    = 1'b1;
        mem_rdata  = 8'hEE;
        wait_cnt   = 0;
      end else if (mem_ack) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (mem_req) begin
        if (wait_cnt == 0) req_log.push_back(mem_addr);
        wait_cnt++;
        if (wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_fn(mem_addr);
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: every accepted instruction must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && !jump && instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pop: instr 0x%0h pc 0x%0h with nothing expected",
                   instr, instr_pc);
        end else begin
          e = exp_q.pop_front();
          check("instr", 32'(instr), 32'(e.data));
          check("instr_pc", 32'(instr_pc), 32'(e.pc));
        end
      end
    end
  end

  initial begin
    reset       = 1'b1;
    halt        = 1'b0;
    instr_ready = 1'b1;
    jump        = 1'b0;
    jump_addr   = '0;

    // Reset state
    repeat (3) step();
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_instr_valid", 32'(instr_valid), 0);
    check("rst_instr", 32'(instr), 0);
    check("rst_instr_pc", 32'(instr_pc), 0);

    // Sequential fetch from 0, then jump to 0x40 while the read of 0x03 is pending
    push_exp(8'h5A, 8'h01);
    push_exp(8'h5B, 8'h02);
    push_exp(8'h58, 8'h03);
    reset = 1'b0;
    begin
      int n = 0;
      while (req_log.size() < 3 && n < 100) begin
        step();
        n++;
      end
      if (req_log.size() < 3) timeout("seq_reqs");
      ack_delay = 1000;
      n = 0;
      while (!(mem_req && mem_addr == 8'h03) && n < 100) begin
        step();
        n++;
      end
      if (!(mem_req && mem_addr == 8'h03)) timeout("wait_addr3");
    end
    step();
    push_exp(8'h1A, 8'h41);
    push_exp(8'h1B, 8'h42);
    jump      = 1'b1;
    jump_addr = 8'h40;
    step();
    jump = 1'b0;
    check("post_jump_valid", 32'(instr_valid), 0);
    check("discard_holds_req", 32'(mem_req), 1);
    check("discard_holds_addr", 32'(mem_addr), 32'h03);
    ack_delay = 1;
    drain("drain_jump");
    check("log_size", 32'(req_log.size() >= 6), 1);
    check("log0", 32'(req_log[0]), 32'h00);
    check("log1", 32'(req_log[1]), 32'h01);
    check("log2", 32'(req_log[2]), 32'h02);
    check("log3", 32'(req_log[3]), 32'h03);
    check("log4_jump", 32'(req_log[4]), 32'h40);
    check("log5", 32'(req_log[5]), 32'h41);

    // Address wrap 0xFF -> 0x00
    quiesce(8'hFE);
    push_exp(8'hA4, 8'hFF);
    push_exp(8'hA5, 8'h00);
    push_exp(8'h5A, 8'h01);
    halt        = 1'b0;
    instr_ready = 1'b1;
    drain("drain_wrap");
    check("wrap_log0", 32'(req_log[0]), 32'hFE);
    check("wrap_log1", 32'(req_log[1]), 32'hFF);
    check("wrap_log2", 32'(req_log[2]), 32'h00);

    // Consumer stalled: request count depends on queue depth
    quiesce(8'h10);
    halt = 1'b0;
    repeat (10) step();
`ifdef FETCH_PREFETCH_EN
    check("stall_reqs", 32'(req_log.size()), 2);
    push_exp(8'h4A, 8'h11);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    repeat (10) step();
    check("one_pop_one_req", 32'(req_log.size()), 3);
    check("refill_addr", 32'(req_log[2]), 32'h12);
    check("stall_head", 32'(instr), 32'h4B);
`else
    check("stall_reqs", 32'(req_log.size()), 0);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    repeat (10) step();
    check("demand_reqs", 32'(req_log.size()), 1);
    check("demand_valid", 32'(instr_valid), 1);
    check("demand_instr", 32'(instr), 32'h4A);
    check("demand_pc", 32'(instr_pc), 32'h11);
`endif
    drain("drain_stall");

    // Halt while a read is outstanding: it completes, nothing new until release
    quiesce(8'h20);
    ack_delay = 1000;
    push_exp(8'h7A, 8'h21);
    instr_ready = 1'b1;
    halt        = 1'b0;
    wait_req("halt_req");
    check("halt_req_addr", 32'(mem_addr), 32'h20);
    halt = 1'b1;
    repeat (2) step();
    ack_delay = 1;
    drain("drain_halt");
    repeat (10) step();
    check("halt_no_reqs", 32'(req_log.size()), 1);
    check("halt_req_low", 32'(mem_req), 0);
    push_exp(8'h7B, 8'h22);
    halt = 1'b0;
    wait_req("unhalt_req");
    check("unhalt_addr", 32'(mem_addr), 32'h21);
    drain("drain_unhalt");

    // Reset with a read pending, stray ack in the first cycle after reset
    quiesce(8'h30);
    ack_delay   = 1000;
    instr_ready = 1'b1;
    halt        = 1'b0;
    wait_req("pre_reset_req");
    reset = 1'b1;
    stray_req++;
    step();
    reset     = 1'b0;
    ack_delay = 1;
    req_log.delete();
    check("reset_req_low", 32'(mem_req), 0);
    push_exp(8'h5A, 8'h01);
    step();
    check("stray_ack_ignored", 32'(instr_valid), 0);
    drain("drain_reset");
    check("after_reset_addr", 32'(req_log[0]), 32'h00);

    halt        = 1'b1;
    instr_ready = 1'b0;
    repeat (5) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning memory address and PC width in bits.
REQ-002 SHALL have parameter DATA_W, default 8, meaning instruction and memory data width in bits.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port reset, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port mem_req, output, 1, instruction-read request to memory.
REQ-006 SHALL have port mem_addr, output, ADDR_W, read address; stable while mem_req is high.
REQ-007 SHALL have port mem_ack, input, 1, single-cycle pulse; mem_rdata is valid in that cycle.
REQ-008 SHALL have port mem_rdata, input, DATA_W, returned instruction byte.
REQ-009 SHALL have port instr_valid, output, 1, instr holds a fetched instruction.
REQ-010 SHALL have port instr_ready, input, 1, consumer accepts instr (control sequencer in FETCH).
REQ-011 SHALL have port instr, output, DATA_W, head instruction.
REQ-012 SHALL have port instr_pc, output, ADDR_W, address of head instruction plus 1.
REQ-013 SHALL have port jump, input, 1, redirect pulse.
REQ-014 SHALL have port jump_addr, input, ADDR_W, redirect target.
REQ-015 SHALL have port halt, input, 1, level; no new memory requests while high.

Function
REQ-016 SHALL complete a memory transfer when mem_req and mem_ack are both high; mem_ack without mem_req SHALL be ignored.
REQ-017 SHALL complete a consumer transfer (pop) when instr_valid and instr_ready are both high.
REQ-018 SHALL hold mem_req high with mem_addr constant from issue until ack, regardless of jump or halt.
REQ-019 SHALL use request FSM states IDLE, WAIT_ACK, DISCARD.
REQ-020 SHALL go IDLE->WAIT_ACK when halt=0 and queue has a free entry; mem_addr=fetch_addr.
REQ-021 SHALL on ack in WAIT_ACK push mem_rdata with its address, increment fetch_addr modulo 2^ADDR_W (0xFF->0x00), then go IDLE.
REQ-022 SHALL on jump: flush queue, set fetch_addr=jump_addr; if WAIT_ACK, go DISCARD.
REQ-023 SHALL in DISCARD drop the acked data without pushing, then go IDLE.
REQ-024 SHALL give jump priority over simultaneous pop and push; neither takes effect that cycle.
REQ-025 SHALL deassert instr_valid in the cycle after a jump; first post-jump instr_valid no earlier than 2 cycles after ack of jump_addr request issue.
REQ-026 SHALL allow push and pop in the same cycle on a full queue only if a pop frees the entry (no overflow, no data loss).
REQ-027 SHALL present push data on instr no earlier than the cycle after ack (registered output).
REQ-028 SHALL let an outstanding request complete while halt=1.

Reset
REQ-029 SHALL on reset: mem_req=0, mem_addr=0, instr_valid=0, instr=0, instr_pc=0, fetch_addr=0, queue empty, FSM=IDLE.
REQ-030 SHALL abandon any outstanding request on reset; an ack arriving in the first cycle after reset SHALL be ignored.

Configuration
REQ-031 SHALL with FETCH_PREFETCH_EN defined use a 2-entry queue and request whenever an entry is free.
REQ-032 SHALL without FETCH_PREFETCH_EN use 1 entry and issue a request only when the queue is empty and instr_ready=1.

Structure
REQ-033 SHALL place FSM state encodings and queue depth constants in shared package cpu_pkg.
REQ-034 SHALL implement the queue as sub-module fetch_queue (push, pop, flush, full, empty).

Verification
REQ-035 Reset, halt=0, ack 1 cycle after each req -> mem_addr 0x00,0x01,...; instr=mem[0], instr_pc=0x01.
REQ-036 Jump to 0x40 while WAIT_ACK at 0x03 -> ack data for 0x03 dropped; next mem_addr=0x40; first instr=mem[0x40], instr_pc=0x41.
REQ-037 fetch_addr=0xFF, ack -> next mem_addr=0x00; instr_pc for that instr=0x00.
REQ-038 Prefetch on, instr_ready=0 -> exactly 2 requests then mem_req stays 0; one pop -> one new request.
REQ-039 halt=1 while WAIT_ACK -> that ack pushes; no further mem_req until halt=0.
REQ-040 Reset asserted in WAIT_ACK, ack next cycle -> queue stays empty, instr_valid=0, next mem_addr=0x00.
